pipe_hazard_ctrl: RTL and testbench

Parametrised sequential successor to the Y86 pipeline control logic. Generates stall, bubble and condition-code-enable controls for all five stages (F/D/E/M/W), adding three things: a multi-cycle data-memory wait state machine, exception-driven flushing with a sticky halt state, and saturating stall/bubble performance counters. Sits beside the pipeline registers and drives their stall/bubble pins directly.

---
 rtl/y86_pkg.sv | 33 +++
 rtl/pipe_hazard_ctrl_if.sv | 29 ++
 rtl/pipe_mem_wait_fsm.sv | 61 ++++++
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
`default_nettype none
// y86_pkg: icode, status-code and register constants shared by the pipeline control blocks.
// Rev 1.0
package y86_pkg;

  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } wait_state_e;

  function automatic logic is_mem_icode(input logic [3:0] icode);
    return icode inside {I_RMMOV, I_MRMOV, I_CALL, I_RET, I_PUSH, I_POP};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// pipe_hazard_ctrl_if: pipeline state seen by the hazard controller and the controls it returns.
// Rev 1.0
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       D_icode, E_icode, M_icode;
  logic [3:0]       E_dstM, d_srcA, d_srcB;
  logic             e_Cnd;
  logic [2:0]       m_stat, W_stat;
  logic             clr_cnt;
  logic             F_stall, D_stall, E_stall, M_stall, W_stall;
  logic             D_bubble, E_bubble, M_bubble, W_bubble;
  logic             set_cc_en, halted;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  modport master (
    output D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat, clr_cnt,
    input  F_stall, D_stall, E_stall, M_stall, W_stall,
    input  D_bubble, E_bubble, M_bubble, W_bubble, set_cc_en, halted, stall_cnt, bubble_cnt
  );

  modport slave (
    input  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat, clr_cnt,
    output F_stall, D_stall, E_stall, M_stall, W_stall,
    output D_bubble, E_bubble, M_bubble, W_bubble, set_cc_en, halted, stall_cnt, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_mem_wait_fsm.sv
`default_nettype none
// pipe_mem_wait_fsm: holds the pipe while a multi-cycle data access completes; latches halt on W exceptions.
// Rev 1.0
module pipe_mem_wait_fsm #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic memop,
  input  logic w_exc,
  output logic mem_hold,
  output logic halted
);
  import y86_pkg::*;

  localparam int WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_INIT = (MEM_LAT > 1) ? WCNT_W'(MEM_LAT - 2) : '0;

  wait_state_e       state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // The entry cycle already counts as the first hold cycle, hence the -2 preload.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    mem_hold  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (w_exc) begin
          state_nxt = ST_HALT;
        end else if (memop && (MEM_LAT > 1)) begin
          mem_hold  = 1'b1;
          state_nxt = ST_WAIT;
          wcnt_nxt  = WCNT_INIT;
        end
      end
      ST_WAIT: begin
        mem_hold = (wcnt != '0);
        if (w_exc)             state_nxt = ST_HALT;
        else if (wcnt == '0)   state_nxt = ST_IDLE;
        else                   wcnt_nxt  = wcnt - WCNT_W'(1);
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign halted = (state == ST_HALT);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// pipe_hazard_ctrl: five-stage stall/bubble/CC-enable control with memory wait, halt and perf counters.
// Rev 1.0
module pipe_hazard_ctrl #(
  parameter int         MEM_LAT = 1,
  parameter int         CNT_W   = 16,
  parameter logic [3:0] RNONE   = y86_pkg::RNONE
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  import y86_pkg::*;

  logic load_use, mispred, ret_any, m_exc, w_exc, memop;
  logic mem_hold, halted;
  logic f_stall, d_stall, e_stall, m_stall, w_stall;
  logic d_bubble, e_bubble, m_bubble, w_bubble, set_cc;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  assign load_use = (bus.E_icode == I_MRMOV || bus.E_icode == I_POP) && (bus.E_dstM != RNONE) &&
                    (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
  assign mispred  = (bus.E_icode == I_JXX) && !bus.e_Cnd;
  assign ret_any  = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
  assign m_exc    = bus.m_stat inside {S_HLT, S_ADR, S_INS};
  assign w_exc    = (bus.W_stat != S_AOK);
  assign memop    = is_mem_icode(bus.M_icode) && (bus.m_stat == S_AOK);

  pipe_mem_wait_fsm #(
    .MEM_LAT (MEM_LAT)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .memop    (memop),
    .w_exc    (w_exc),
    .mem_hold (mem_hold),
    .halted   (halted)
  );

  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    e_stall  = 1'b0;
    m_stall  = 1'b0;
    w_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_bubble = 1'b0;
    set_cc   = 1'b0;
    if (halted) begin
      {f_stall, d_stall, e_stall, m_stall, w_stall} = '1;
    end else if (mem_hold) begin
      {f_stall, d_stall, e_stall, m_stall} = '1;
      w_bubble = 1'b1;
    end else begin
      f_stall  = load_use | ret_any;
      d_stall  = load_use;
      d_bubble = mispred | (ret_any & ~load_use);
      e_bubble = mispred | load_use;
      m_bubble = m_exc | w_exc;
      w_stall  = w_exc;
      // A faulting instruction ahead must not let E commit its flags.
      set_cc   = (bus.E_icode == I_OP) && !m_exc && !w_exc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (bus.clr_cnt) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (f_stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((d_bubble || e_bubble) && !(&bubble_cnt))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.F_stall    = f_stall;
  assign bus.D_stall    = d_stall;
  assign bus.E_stall    = e_stall;
  assign bus.M_stall    = m_stall;
  assign bus.W_stall    = w_stall;
  assign bus.D_bubble   = d_bubble;
  assign bus.E_bubble   = e_bubble;
  assign bus.M_bubble   = m_bubble;
  assign bus.W_bubble   = w_bubble;
  assign bus.set_cc_en  = set_cc;
  assign bus.halted     = halted;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.bubble_cnt = bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// tb_pipe_hazard_ctrl: directed scoreboard bench for two controller instances (MEM_LAT=4/CNT_W=4, MEM_LAT=3).
// Rev 1.0
module tb_pipe_hazard_ctrl;

  // Control vector: {F,D,E,M,W stall, D,E,M,W bubble, set_cc_en, halted}
  localparam logic [10:0] V_NONE = 11'b00000_0000_0_0;
  localparam logic [10:0] V_LU   = 11'b11000_0100_0_0;
  localparam logic [10:0] V_MRET = 11'b10000_1100_0_0;
  localparam logic [10:0] V_RET  = 11'b10000_1000_0_0;
  localparam logic [10:0] V_CC   = 11'b00000_0000_1_0;
  localparam logic [10:0] V_MEXC = 11'b00000_0010_0_0;
  localparam logic [10:0] V_WEXC = 11'b00001_0010_0_0;
  localparam logic [10:0] V_HOLD = 11'b11110_0001_0_0;
  localparam logic [10:0] V_HALT = 11'b11111_0000_0_1;

  localparam int K_CTL4 = 0;
  localparam int K_SC4  = 1;
  localparam int K_BC4  = 2;
  localparam int K_CTL3 = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
  logic       e_Cnd, clr_cnt;
  logic [2:0] m_stat, W_stat;

  int  vectors = 0;
  int  miscompares = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) bus3 ();

  assign bus4.D_icode = D_icode;  assign bus3.D_icode = D_icode;
  assign bus4.E_icode = E_icode;  assign bus3.E_icode = E_icode;
  assign bus4.M_icode = M_icode;  assign bus3.M_icode = M_icode;
  assign bus4.E_dstM  = E_dstM;   assign bus3.E_dstM  = E_dstM;
  assign bus4.d_srcA  = d_srcA;   assign bus3.d_srcA  = d_srcA;
  assign bus4.d_srcB  = d_srcB;   assign bus3.d_srcB  = d_srcB;
  assign bus4.e_Cnd   = e_Cnd;    assign bus3.e_Cnd   = e_Cnd;
  assign bus4.m_stat  = m_stat;   assign bus3.m_stat  = m_stat;
  assign bus4.W_stat  = W_stat;   assign bus3.W_stat  = W_stat;
  assign bus4.clr_cnt = clr_cnt;  assign bus3.clr_cnt = clr_cnt;

  pipe_hazard_ctrl #(.MEM_LAT(4), .CNT_W(4), .RNONE(4'hF)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(16), .RNONE(4'hF)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  function automatic logic [31:0] observe(input int kind);
    logic [31:0] v;
    v = '0;
    case (kind)
      K_CTL4: v = 32'({bus4.F_stall, bus4.D_stall, bus4.E_stall, bus4.M_stall, bus4.W_stall,
                       bus4.D_bubble, bus4.E_bubble, bus4.M_bubble, bus4.W_bubble,
                       bus4.set_cc_en, bus4.halted});
      K_SC4:  v = 32'(bus4.stall_cnt);
      K_BC4:  v = 32'(bus4.bubble_cnt);
      K_CTL3: v = 32'({bus3.F_stall, bus3.D_stall, bus3.E_stall, bus3.M_stall, bus3.W_stall,
                       bus3.D_bubble, bus3.E_bubble, bus3.M_bubble, bus3.W_bubble,
                       bus3.set_cc_en, bus3.halted});
      default: v = 'x;
    endcase
    return v;
  endfunction

  task automatic expect_v(input string tag, input int kind, input logic [31:0] v);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      sb_t e;
      logic [31:0] obs;
      e   = sb.pop_front();
      obs = observe(e.kind);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 2 ns later, well clear of the rising edge.
  task automatic step();
    #2;
    drain();
    @(negedge clk);
  endtask

  task automatic nop_in();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    E_dstM  = 4'hF; d_srcA  = 4'hF; d_srcB  = 4'hF;
    e_Cnd   = 1'b1; m_stat  = 3'd1; W_stat  = 3'd1; clr_cnt = 1'b0;
  endtask

  task automatic load_use_in();
    nop_in();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
  endtask

  initial begin
    nop_in();
    @(negedge clk);
    expect_v("reset_ctl", K_CTL4, 32'(V_NONE));
    expect_v("reset_scnt", K_SC4, 32'd0);
    expect_v("reset_bcnt", K_BC4, 32'd0);
    expect_v("reset_ctl3", K_CTL3, 32'(V_NONE));
    step();
    rst_n = 1'b1;

    nop_in();                         expect_v("nop_idle", K_CTL4, 32'(V_NONE)); step();
    load_use_in();                    expect_v("load_use", K_CTL4, 32'(V_LU));   step();
    nop_in(); E_icode = 4'h5;         expect_v("load_rnone", K_CTL4, 32'(V_NONE)); step();
    nop_in(); E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
                                      expect_v("mispred_ret", K_CTL4, 32'(V_MRET)); step();
    nop_in(); E_icode = 4'h9;         expect_v("ret_in_e", K_CTL4, 32'(V_RET)); step();
    nop_in(); E_icode = 4'h6;         expect_v("op_setcc", K_CTL4, 32'(V_CC)); step();
    nop_in(); E_icode = 4'h6; m_stat = 3'd3;
                                      expect_v("m_exc", K_CTL4, 32'(V_MEXC)); step();

    nop_in(); clr_cnt = 1'b1;
    expect_v("scnt_pre_clr", K_SC4, 32'd3);
    expect_v("bcnt_pre_clr", K_BC4, 32'd3);
    step();
    nop_in();
    expect_v("scnt_cleared", K_SC4, 32'd0);
    expect_v("bcnt_cleared", K_BC4, 32'd0);
    step();

    // MEM_LAT=4: three hold cycles, then release while the load is still in M.
    nop_in(); M_icode = 4'h5;
    for (int i = 0; i < 3; i++) begin
      expect_v($sformatf("mem_hold_%0d", i), K_CTL4, 32'(V_HOLD));
      step();
    end
    expect_v("mem_release", K_CTL4, 32'(V_NONE)); step();
    nop_in();
    expect_v("mem_after", K_CTL4, 32'(V_NONE));
    expect_v("mem_scnt", K_SC4, 32'd3);
    expect_v("mem_bcnt", K_BC4, 32'd0);
    step();

    nop_in(); E_icode = 4'h6; m_stat = 3'd3;
                                      expect_v("exc_m", K_CTL4, 32'(V_MEXC)); step();
    nop_in(); E_icode = 4'h6; W_stat = 3'd3;
                                      expect_v("exc_w", K_CTL4, 32'(V_WEXC)); step();
    nop_in(); E_icode = 4'h6;         expect_v("halted", K_CTL4, 32'(V_HALT)); step();
    load_use_in();                    expect_v("halt_sticky", K_CTL4, 32'(V_HALT)); step();

    nop_in();
    rst_n = 1'b0;
    expect_v("halt_async_rst", K_CTL4, 32'(V_NONE));
    expect_v("halt_rst_scnt", K_SC4, 32'd0);
    expect_v("halt_rst_bcnt", K_BC4, 32'd0);
    step();
    rst_n = 1'b1;
    expect_v("post_rst_nop", K_CTL4, 32'(V_NONE)); step();

    // CNT_W=4 saturation, then clear racing an increment.
    load_use_in();
    for (int i = 0; i < 20; i++) begin
      expect_v($sformatf("sat_lu_%0d", i), K_CTL4, 32'(V_LU));
      step();
    end
    clr_cnt = 1'b1;
    expect_v("sat_scnt", K_SC4, 32'd15);
    expect_v("sat_bcnt", K_BC4, 32'd15);
    step();
    clr_cnt = 1'b0;
    expect_v("clr_wins_s", K_SC4, 32'd0);
    expect_v("clr_wins_b", K_BC4, 32'd0);
    step();
    expect_v("count_resume", K_SC4, 32'd1); step();

    nop_in();
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();

    // MEM_LAT=3: reset in the second hold cycle must drop the hold at once.
    nop_in(); M_icode = 4'h5;
    expect_v("l3_hold_0", K_CTL3, 32'(V_HOLD)); step();
    expect_v("l3_hold_1", K_CTL3, 32'(V_HOLD));
    #2;
    drain();
    nop_in();
    #1;
    expect_v("l3_nop_in_wait", K_CTL3, 32'(V_HOLD));
    drain();
    rst_n = 1'b0;
    #1;
    expect_v("l3_async_rst", K_CTL3, 32'(V_NONE));
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    expect_v("l3_post_rst", K_CTL3, 32'(V_NONE)); step();
    expect_v("l3_post_rst2", K_CTL3, 32'(V_NONE)); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
